// File: rtl/lcd_display_ctrl_if.sv
// Character stream from the display controller to the LCD: one ASCII character
// plus its digit position, transferred on valid && ready.
interface lcd_display_ctrl_if #(
    parameter int unsigned POS_W = 2
);
    logic [7:0]       lcd_data;
    logic [POS_W-1:0] lcd_pos;
    logic             lcd_valid;
    logic             lcd_ready;

    modport master (
        output lcd_data,
        output lcd_pos,
        output lcd_valid,
        input  lcd_ready
    );

    modport slave (
        input  lcd_data,
        input  lcd_pos,
        input  lcd_valid,
        output lcd_ready
    );
endinterface

// File: rtl/lcd_display_ctrl.sv
// Multi-digit BCD to ASCII LCD streamer with source select and latched alarm.
// Optional build macro BLANK_LEADING_ZERO_EN sends leading zero digits as spaces.
module lcd_display_ctrl #(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned POS_W    = 2,
    parameter logic [7:0]  ERR_CHAR = 8'h3A
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   alarm_time,
    input  logic [4*DIGITS-1:0]   current_time,
    input  logic [4*DIGITS-1:0]   key_buffer,
    input  logic                  show_alarm,
    input  logic                  show_new_time,
    input  logic                  refresh,
    input  logic                  stop_alarm,
    lcd_display_ctrl_if.master    lcd,
    output logic                  frame_done,
    output logic                  sound_alarm
);

    typedef enum logic [1:0] {
        MODE_CURRENT,
        MODE_ALARM,
        MODE_KEY
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    mode_e               mode_q, mode_d;
    logic [4*DIGITS-1:0] frame_q, frame_d;
    logic [POS_W-1:0]    idx_q, idx_d;
    logic                match_q, match_d;
    logic                sound_q, sound_d;
    logic                lead_q, lead_d;

    logic [4*DIGITS-1:0] shifted;
    logic [3:0]          nib;
    logic [7:0]          ch;
    logic                last;
    logic                accept;
    logic                match;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_CURRENT;
            frame_q <= '0;
            idx_q   <= '0;
            match_q <= 1'b0;
            sound_q <= 1'b0;
            lead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            frame_q <= frame_d;
            idx_q   <= idx_d;
            match_q <= match_d;
            sound_q <= sound_d;
            lead_q  <= lead_d;
        end
    end

    // Both selects high keeps whatever source was last chosen.
    always_comb begin
        mode_d = mode_q;
        case ({show_alarm, show_new_time})
            2'b10:   mode_d = MODE_ALARM;
            2'b00:   mode_d = MODE_CURRENT;
            2'b01:   mode_d = MODE_KEY;
            default: mode_d = mode_q;
        endcase
    end

    always_comb begin
        shifted = frame_q >> (4 * (DIGITS - 1 - 32'(idx_q)));
        nib     = shifted[3:0];
        last    = (idx_q == POS_W'(DIGITS - 1));
        ch      = (nib <= 4'd9) ? (8'h30 + {4'h0, nib}) : ERR_CHAR;
`ifdef BLANK_LEADING_ZERO_EN
        if (lead_q && (nib == 4'd0) && !last) begin
            ch = 8'h20;
        end
`endif
    end

    assign lcd.lcd_valid = (state_q == ST_SEND);
    assign lcd.lcd_data  = (state_q == ST_SEND) ? ch : 8'h00;
    assign lcd.lcd_pos   = (state_q == ST_SEND) ? idx_q : '0;
    assign frame_done    = (state_q == ST_DONE);
    assign accept        = lcd.lcd_valid && lcd.lcd_ready;

    always_comb begin
        state_d = state_q;
        frame_d = frame_q;
        idx_d   = idx_q;
        lead_d  = lead_q;
        case (state_q)
            ST_IDLE: begin
                if (refresh) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                case (mode_q)
                    MODE_ALARM: frame_d = alarm_time;
                    MODE_KEY:   frame_d = key_buffer;
                    default:    frame_d = current_time;
                endcase
                idx_d   = '0;
                lead_d  = 1'b1;
                state_d = ST_SEND;
            end
            ST_SEND: begin
                if (accept) begin
                    // Blanking continues only while every digit so far was zero.
                    lead_d = lead_q && (nib == 4'd0);
                    if (last) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + POS_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign match = (current_time == alarm_time);

    // Stop has priority so a clear issued on the arming edge still wins.
    always_comb begin
        match_d = match;
        sound_d = sound_q;
        if (stop_alarm) begin
            sound_d = 1'b0;
        end else if (match && !match_q) begin
            sound_d = 1'b1;
        end
    end

    assign sound_alarm = sound_q;

endmodule

// File: tb/tb_lcd_display_ctrl.sv
// Directed bench for lcd_display_ctrl: frame streaming, source select, alarm latch
// and asynchronous reset mid-frame.
module tb_lcd_display_ctrl;
    localparam int unsigned DIGITS = 4;
    localparam int unsigned POS_W  = 2;
`ifdef BLANK_LEADING_ZERO_EN
    localparam logic [7:0] LZ = 8'h20;
`else
    localparam logic [7:0] LZ = 8'h30;
`endif

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [4*DIGITS-1:0] alarm_time;
    logic [4*DIGITS-1:0] current_time;
    logic [4*DIGITS-1:0] key_buffer;
    logic                show_alarm;
    logic                show_new_time;
    logic                refresh;
    logic                stop_alarm;
    logic                frame_done;
    logic                sound_alarm;

    int unsigned errors = 0;
    int unsigned checks = 0;

    always #5 clock = ~clock;

    lcd_display_ctrl_if #(.POS_W(POS_W)) bus ();

    lcd_display_ctrl #(
        .DIGITS  (DIGITS),
        .POS_W   (POS_W),
        .ERR_CHAR(8'h3A)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .alarm_time   (alarm_time),
        .current_time (current_time),
        .key_buffer   (key_buffer),
        .show_alarm   (show_alarm),
        .show_new_time(show_new_time),
        .refresh      (refresh),
        .stop_alarm   (stop_alarm),
        .lcd          (bus.master),
        .frame_done   (frame_done),
        .sound_alarm  (sound_alarm)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // exp_word holds the four expected characters, pos 0 in the top byte.
    task automatic run_frame(input string tag, input logic [31:0] exp_word, input bit toggle);
        int unsigned k = 0;
        int unsigned cyc = 0;
        logic [7:0] held = 8'h00;
        bit have_held = 1'b0;
        @(posedge clock); #1;
        refresh = 1'b1;
        bus.lcd_ready = 1'b1;
        @(posedge clock); #1;
        refresh = 1'b0;
        @(negedge clock);
        check({tag, ":load_valid"}, 32'(bus.lcd_valid), 32'd0);
        while (k < 4 && cyc < 40) begin
            @(posedge clock); #1;
            if (toggle) bus.lcd_ready = ~bus.lcd_ready;
            @(negedge clock);
            cyc++;
            check({tag, ":valid"}, 32'(bus.lcd_valid), 32'd1);
            if (have_held) check({tag, ":held"}, 32'(bus.lcd_data), 32'(held));
            if (bus.lcd_ready) begin
                check({tag, ":data"}, 32'(bus.lcd_data), 32'(exp_word[31-8*k -: 8]));
                check({tag, ":pos"}, 32'(bus.lcd_pos), k);
                k++;
                have_held = 1'b0;
            end else begin
                held = bus.lcd_data;
                have_held = 1'b1;
            end
        end
        check({tag, ":cycles"}, cyc, toggle ? 32'd8 : 32'd4);
        @(posedge clock); #1;
        bus.lcd_ready = 1'b1;
        @(negedge clock);
        check({tag, ":done"}, 32'(frame_done), 32'd1);
        check({tag, ":done_valid"}, 32'(bus.lcd_valid), 32'd0);
        @(negedge clock);
        check({tag, ":done_pulse"}, 32'(frame_done), 32'd0);
    endtask

    task automatic step();
        @(posedge clock); #1;
    endtask

    initial begin
        int unsigned guard;
        alarm_time    = 16'h0705;
        current_time  = 16'h1234;
        key_buffer    = 16'h9AF0;
        show_alarm    = 1'b0;
        show_new_time = 1'b0;
        refresh       = 1'b0;
        stop_alarm    = 1'b0;
        bus.lcd_ready = 1'b1;

        #12;
        check("rst_data", 32'(bus.lcd_data), 32'd0);
        check("rst_pos", 32'(bus.lcd_pos), 32'd0);
        check("rst_valid", 32'(bus.lcd_valid), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_sound", 32'(sound_alarm), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        run_frame("cur1234", 32'h31323334, 1'b0);

        show_alarm = 1'b1;
        run_frame("alm0705", {LZ, 24'h373035}, 1'b1);

        show_alarm = 1'b0;
        show_new_time = 1'b1;
        run_frame("key9AF0", 32'h393A3A30, 1'b0);
        show_alarm = 1'b1;
        run_frame("keyhold", 32'h393A3A30, 1'b0);

        show_alarm = 1'b0;
        show_new_time = 1'b0;
        current_time = 16'h0030;
        run_frame("cur0030", {LZ, LZ, 16'h3330}, 1'b0);
        current_time = 16'h0000;
        run_frame("cur0000", {LZ, LZ, LZ, 8'h30}, 1'b0);
        check("no_alarm", 32'(sound_alarm), 32'd0);

        alarm_time = 16'h0700;
        current_time = 16'h0659;
        step(); step();
        current_time = 16'h0700;
        @(negedge clock);
        check("alm_pre", 32'(sound_alarm), 32'd0);
        @(negedge clock);
        check("alm_set", 32'(sound_alarm), 32'd1);
        step();
        stop_alarm = 1'b1;
        step();
        stop_alarm = 1'b0;
        @(negedge clock);
        check("alm_stop", 32'(sound_alarm), 32'd0);
        step(); step(); step();
        @(negedge clock);
        check("alm_persist", 32'(sound_alarm), 32'd0);
        step();
        current_time = 16'h0701;
        step();
        current_time = 16'h0700;
        @(negedge clock);
        @(negedge clock);
        check("alm_reset", 32'(sound_alarm), 32'd1);
        step();
        stop_alarm = 1'b1;
        step();
        stop_alarm = 1'b0;
        current_time = 16'h0701;
        step();
        current_time = 16'h0700;
        stop_alarm = 1'b1;
        step();
        stop_alarm = 1'b0;
        @(negedge clock);
        check("alm_stopwins", 32'(sound_alarm), 32'd0);
        step(); step();
        @(negedge clock);
        check("alm_stopwins2", 32'(sound_alarm), 32'd0);

        alarm_time = 16'h0705;
        current_time = 16'h1234;
        step();
        refresh = 1'b1;
        step();
        refresh = 1'b0;
        guard = 0;
        @(negedge clock);
        while (!(bus.lcd_valid && bus.lcd_pos == 2'd2) && guard < 20) begin
            @(negedge clock);
            guard++;
        end
        check("mid_pos2", 32'(bus.lcd_pos), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        check("mid_data", 32'(bus.lcd_data), 32'd0);
        check("mid_pos", 32'(bus.lcd_pos), 32'd0);
        check("mid_valid", 32'(bus.lcd_valid), 32'd0);
        check("mid_done", 32'(frame_done), 32'd0);
        @(negedge clock);
        check("mid_hold_valid", 32'(bus.lcd_valid), 32'd0);
        reset = 1'b1;
        current_time = 16'h5678;
        @(negedge clock);
        check("post_idle", 32'(bus.lcd_valid), 32'd0);
        run_frame("cur5678", 32'h35363738, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
